// File: rtl/weight_stream_reader.sv
// rtl/weight_stream_reader.sv - streams DEPTH weights from a negedge BRAM to a MAC over valid/ready
// Optional running checksum of transferred words: define WEIGHT_STREAM_CHECKSUM_EN.
module weight_stream_reader #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [ADDR_W-1:0] W_INDEX,
  output logic              W_LAST,
  output logic              BUSY,
  output logic              DONE
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] CHECKSUM
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [1:0]        count;
  logic [1:0]        occ;
  logic              rd_ptr, wr_ptr;
  logic              push, pop, issue, start_ok;

  logic [DATA_W-1:0] buf_data  [2];
  logic [ADDR_W-1:0] buf_index [2];
  logic              buf_last  [2];

  // The read issued last cycle lands in the buffer on this edge.
  assign push    = BRAM_EN;
  assign W_VALID = (count != 2'd0);
  assign pop     = W_VALID && W_READY;
  // Occupancy after this edge, before any new issue; issuing keeps it <= 2.
  assign occ     = count + 2'(push) - 2'(pop);

  assign W_DATA  = W_VALID ? buf_data[rd_ptr]  : '0;
  assign W_INDEX = W_VALID ? buf_index[rd_ptr] : '0;
  assign W_LAST  = W_VALID && buf_last[rd_ptr];
  assign BRAM_WE = 1'b0;
  assign BUSY    = (state == S_FETCH) || (state == S_DRAIN);
  assign DONE    = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    issue     = 1'b0;
    start_ok  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          start_ok  = 1'b1;
          ptr_nxt   = '0;
          state_nxt = S_FETCH;
        end else if (state == S_DONE) begin
          state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (occ < 2'd2) begin
          issue = 1'b1;
          if (ptr == LAST_ADDR) begin
            state_nxt = S_DRAIN;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (occ == 2'd0) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= '0;
      BRAM_ADDR <= '0;
      BRAM_EN   <= 1'b0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      BRAM_EN <= issue;
      count   <= occ;
      if (issue) BRAM_ADDR <= ptr;
      if (push)  wr_ptr    <= ~wr_ptr;
      if (pop)   rd_ptr    <= ~rd_ptr;
    end
  end

  // Entries are gated by count, so storage needs no reset.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      buf_data[wr_ptr]  <= BRAM_DO;
      buf_index[wr_ptr] <= BRAM_ADDR;
      buf_last[wr_ptr]  <= (BRAM_ADDR == LAST_ADDR);
    end
  end

`ifdef WEIGHT_STREAM_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (RST || start_ok) begin
      CHECKSUM <= '0;
    end else if (pop) begin
      CHECKSUM <= CHECKSUM + (DATA_W + ADDR_W)'(W_DATA);
    end
  end
`endif

endmodule

// File: tb/tb_weight_stream_reader.sv
// tb/tb_weight_stream_reader.sv - scoreboard bench for weight_stream_reader
module tb_weight_stream_reader;

  localparam int DEPTH = 28;

  logic        CLK = 1'b0;
  logic        RST, START, W_READY;
  logic [4:0]  BRAM_ADDR, W_INDEX;
  logic        BRAM_EN, BRAM_WE, W_VALID, W_LAST, BUSY, DONE;
  logic [15:0] BRAM_DO = 16'h0;
  logic [15:0] W_DATA;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  logic [20:0] CHECKSUM;
`endif

  weight_stream_reader #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_DO(BRAM_DO),
    .W_DATA(W_DATA), .W_VALID(W_VALID), .W_READY(W_READY), .W_INDEX(W_INDEX),
    .W_LAST(W_LAST), .BUSY(BUSY), .DONE(DONE)
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    , .CHECKSUM(CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  logic [15:0] bram [32];
  always @(negedge CLK) if (BRAM_EN && !BRAM_WE) BRAM_DO <= bram[BRAM_ADDR];

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  i;
    logic        l;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int issued = 0, xfers = 0, done_cnt = 0;
  int drop = 0, xbase = 0, dbase = 0;
  bit expect_done = 0, stall_prev = 0;
  logic [22:0] stall_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: looks between edges at what the next posedge will do.
  always @(negedge CLK) begin
    if (!RST) begin
      if (BRAM_EN) begin
        issued++;
        chk("addr_range", 32'(BRAM_ADDR < 5'(DEPTH)), 32'd1);
      end
      chk("outstanding_le2", 32'(issued - xfers - drop <= 2), 32'd1);
      if (stall_prev) chk("stall_hold", 32'({W_VALID, W_DATA, W_INDEX, W_LAST}), 32'(stall_word));
      stall_prev = W_VALID && !W_READY;
      stall_word = {W_VALID, W_DATA, W_INDEX, W_LAST};
      if (expect_done) begin
        chk("done_busy_after_last", 32'({DONE, BUSY}), 32'b10);
        expect_done = 0;
      end
      if (DONE) done_cnt++;
      if (W_VALID && W_READY) begin
        xfers++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_word", 32'(W_INDEX), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("w_data", 32'(W_DATA), 32'(e.d));
          chk("w_index", 32'(W_INDEX), 32'(e.i));
          chk("w_last", 32'(W_LAST), 32'(e.l));
          if (W_LAST) expect_done = 1;
        end
      end
    end
  end

  task automatic start_pass();
    for (int i = 0; i < DEPTH; i++) sb.push_back({16'h0100 + 16'(i), 5'(i), i == DEPTH - 1});
    xbase = xfers;
    dbase = done_cnt;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_pass(input int pattern, input bit restart10);
    bit finished = 0;
    bit restarted = 0;
    for (int c = 0; c < 400 && !finished; c++) begin
      W_READY = (pattern == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      @(posedge CLK); #1;
      START = 1'b0;
      if (restart10 && !restarted && (xfers - xbase == 10)) begin
        START = 1'b1;
        restarted = 1;
      end
      if (DONE) finished = 1;
    end
    START = 1'b0;
    W_READY = 1'b1;
    chk("pass_finished", 32'(finished), 32'd1);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("idle_after_done", 32'({BUSY, DONE}), 32'd0);
    end
    chk("done_pulse_count", 32'(done_cnt - dbase), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int ibase;
    for (int i = 0; i < 32; i++) bram[i] = (i < DEPTH) ? 16'h0100 + 16'(i) : 16'hDEAD;
    RST = 1'b1; START = 1'b0; W_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", {BRAM_ADDR, BRAM_EN, BRAM_WE, W_VALID, W_DATA, W_INDEX, W_LAST, BUSY, DONE}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Full-rate pass with first-word latency
    start_pass();
    chk("busy_on_start", 32'(BUSY), 32'd1);
    chk("valid_lat_0", 32'(W_VALID), 32'd0);
    @(posedge CLK); #1;
    chk("valid_lat_1", 32'(W_VALID), 32'd0);
    @(posedge CLK); #1;
    chk("valid_lat_2", 32'(W_VALID), 32'd1);
    wait_pass(0, 0);
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    chk("checksum_final", 32'(CHECKSUM), 32'h1D7A);
`endif

    // Ready toggling 1,0,0,1
    start_pass();
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    chk("checksum_cleared", 32'(CHECKSUM), 32'd0);
`endif
    wait_pass(1, 0);

    // Held-off consumer: only two reads fill the buffer
    W_READY = 1'b0;
    ibase = issued;
    start_pass();
    repeat (10) @(posedge CLK);
    #1;
    chk("stalled_issue_count", 32'(issued - ibase), 32'd2);
    chk("stalled_bram_en", 32'(BRAM_EN), 32'd0);
    W_READY = 1'b1;
    @(posedge CLK); #1;
    chk("resume_addr", 32'({BRAM_EN, BRAM_ADDR}), 32'({1'b1, 5'd2}));
    wait_pass(0, 0);

    // START while busy is ignored
    start_pass();
    wait_pass(0, 1);

    // Reset after the 5th transfer
    start_pass();
    for (int c = 0; c < 100 && (xfers - xbase < 5); c++) begin
      @(posedge CLK); #1;
    end
    chk("five_transfers", 32'(xfers - xbase), 32'd5);
    RST = 1'b1; W_READY = 1'b0;
    @(posedge CLK); #1;
    chk("reset_mid_pass", {BRAM_ADDR, BRAM_EN, BRAM_WE, W_VALID, W_DATA, W_INDEX, W_LAST, BUSY, DONE}, 32'd0);
    RST = 1'b0;
    sb.delete();
    drop = issued - xfers;
    chk("no_done_on_reset", 32'(done_cnt - dbase), 32'd0);
    W_READY = 1'b1;
    @(posedge CLK); #1;
    start_pass();
    wait_pass(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_stream_reader.md
Name: weight_stream_reader

Overview:
- Read-side sequencer for one 16-bit weight BRAM, which samples on negedge CLK and has EN/WE/ADDR/DI/DO ports.
- On a START pulse it walks addresses 0..DEPTH-1, captures DO and presents each weight to the downstream neuron MAC on a valid/ready stream.
- A 2-entry output buffer plus credit accounting absorbs backpressure, so no BRAM read is ever lost.
- Sits between each Weight_x_y BRAM and its MAC unit.

Parameters:
- DEPTH, 28, number of weights per pass (BRAM words 0..DEPTH-1).
- ADDR_W, 5, BRAM address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 16, weight width.

Ports:
- CLK  input  1  system clock; all logic in this block on posedge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle pulse that begins a pass; ignored unless the FSM is in IDLE or DONE.
- BRAM_ADDR  output  ADDR_W  address to the BRAM.
- BRAM_EN  output  1  read enable to the BRAM.
- BRAM_WE  output  1  tied 0; this block never writes.
- BRAM_DO  input  DATA_W  read data from the BRAM.
- W_DATA  output  DATA_W  weight to the MAC.
- W_VALID  output  1  W_DATA is valid.
- W_READY  input  1  MAC accepts the word; a transfer occurs when W_VALID and W_READY are both 1 on a posedge.
- W_INDEX  output  ADDR_W  address that W_DATA came from.
- W_LAST  output  1  high with the word at index DEPTH-1.
- BUSY  output  1  high from START accept until the last word is transferred.
- DONE  output  1  one-cycle pulse on the cycle after the last transfer.

Behaviour:
- Reset values: BRAM_ADDR=0, BRAM_EN=0, BRAM_WE=0, W_VALID=0, W_DATA=0, W_INDEX=0, W_LAST=0, BUSY=0, DONE=0. Buffer count=0, inflight=0, FSM=IDLE.
- BRAM timing: BRAM_ADDR and BRAM_EN are registered on posedge k. The BRAM samples at the following negedge, and BRAM_DO is captured into the buffer at posedge k+1 (read latency 1 cycle).
- FSM states and transitions:
  - IDLE: waits for START; START moves to FETCH, clears the issue pointer and sets BUSY.
  - FETCH: issues a read (BRAM_EN=1, BRAM_ADDR=ptr, ptr++) on any cycle where count + inflight - (pop this cycle) < 2. After issuing address DEPTH-1 it moves to DRAIN.
  - DRAIN: BRAM_EN=0; waits until the buffer is empty and inflight=0, then moves to DONE.
  - DONE: DONE=1 and BUSY=0 for exactly one cycle, then returns to IDLE. A START in the DONE cycle is accepted and goes directly to FETCH.
- BRAM_EN is deasserted on any cycle without an issue.
- Buffer: 2-entry FIFO of {data, index, last}.
  - The head drives W_DATA, W_INDEX and W_LAST; W_VALID = (count != 0).
  - A simultaneous push and pop keeps count unchanged.
- Credits: the issue rule guarantees the buffer never overflows. Steady state with W_READY held at 1 is 1 word per cycle. First W_VALID appears 2 cycles after the START cycle.
- Output stability: W_DATA, W_INDEX and W_LAST hold stable while W_VALID=1 and W_READY=0.
- Pointer: counts 0..DEPTH-1 and never wraps within a pass. Addresses >= DEPTH are never issued.
- START while BUSY (FETCH or DRAIN): ignored, no restart.
- RST mid-pass: the next cycle matches the reset state. The in-flight BRAM read is discarded (no push), the buffer is flushed, and no DONE pulse is produced.
- W_LAST is asserted only for index DEPTH-1 and only while that word is at the buffer head.

Optional Feature:
- Macro WEIGHT_STREAM_CHECKSUM_EN.
- When defined:
  - Adds output CHECKSUM [DATA_W+ADDR_W-1:0], reset 0.
  - Cleared when a START is accepted.
  - On every transfer it accumulates the unsigned W_DATA value.
  - Value is final and stable from the DONE pulse until the next accepted START.
- When undefined: the port and the accumulator are absent; all other behaviour is identical.

Test Plan:
- BRAM preloaded with word i = 16'h0100+i, W_READY=1, pulse START:
  - W_VALID rises 2 cycles after START.
  - 28 consecutive transfers 0x0100..0x011B with W_INDEX 0..27.
  - W_LAST only on 0x011B.
  - DONE pulse 1 cycle after that transfer; BUSY low from then on.
- Same preload, W_READY toggling 1,0,0,1 repeating:
  - All 28 words arrive in order with no loss or duplication.
  - W_DATA is stable during stalls.
  - BRAM_EN never issues while count + inflight = 2.
- W_READY=0 for 10 cycles after START:
  - Exactly 2 reads are issued (addresses 0 and 1), then BRAM_EN=0.
  - Releasing W_READY resumes streaming at index 2.
- START pulsed again while at index 10:
  - Ignored; the stream continues to 27 and exactly one DONE pulse occurs.
- RST asserted after the 5th transfer:
  - All outputs match reset values the next cycle.
  - A fresh START restarts at index 0 with correct data.
- With WEIGHT_STREAM_CHECKSUM_EN and the first test's data:
  - CHECKSUM = 28*0x0100 + 378 = 0x1D7A at the DONE pulse.
  - CHECKSUM returns to 0 on the next accepted START.
